framebuffer_writer: RTL and testbench
=====================================

// Module: framebuffer_writer
// PURPOSE
//  Sink for the rasterizer pixel stream (color, x, y, width, height, draw) leaving the GPU
//  top level. Clears the back buffer at frame start, writes drawn pixels to a linear
//  double-buffered framebuffer RAM and swaps front/back buffers once the frame is finished.
//  Drives the rasterizer's out_ready; the display side reads the buffer selected by front_buf.
// PARAMETERS
//  COLOR_W      8        pixel color width
//  BUF_WORDS    1048576  words per buffer (power of two); buffer b is at base b*BUF_WORDS
//  FB_ADDR_W    21       framebuffer address width, $clog2(2*BUF_WORDS)
//  CLEAR_COLOR  8'h00    value written during clear
// PORTS
//  clk          in   1          clock, all logic on rising edge
//  reset_n      in   1          asynchronous active-low reset
//  frame_start  in   1          pulse: begin new frame (same cycle as GPU start)
//  frame_end    in   1          level from GPU, high when rasterization is finished
//  in_color     in   COLOR_W    pixel color
//  in_x, in_y   in   11         pixel coordinates
//  in_width     in   11         frame width, sampled at frame_start
//  in_height    in   11         frame height, sampled at frame_start
//  in_draw      in   1          1 = pixel covered, write it; 0 = consume, discard
//  in_valid     in   1          pixel valid
//  in_ready     out  1          pixel accepted when in_valid & in_ready
//  fb_wr_en     out  1          framebuffer write request
//  fb_wr_addr   out  FB_ADDR_W  write address
//  fb_wr_data   out  COLOR_W    write data
//  fb_wr_ready  in   1          RAM accepts write when fb_wr_en & fb_wr_ready
//  front_buf    out  1          buffer index to display
//  busy         out  1          state != IDLE
//  swap_done    out  1          1-cycle pulse when front_buf toggles
//  drop_count   out  16         dropped (out-of-range) pixels this frame, saturating
// BEHAVIOUR
//  Reset (async, reset_n=0): state IDLE; every output 0 (front_buf=0, in_ready=0,
//   fb_wr_en=0, drop_count=0); sticky end flag, latched width/height, clear counter cleared.
//  States: IDLE -> CLEAR -> DRAW -> DRAIN -> SWAP -> IDLE.
//  IDLE: in_ready=0. On frame_start: latch W=in_width, H=in_height; total=min(W*H,BUF_WORDS)
//   (22-bit product); clear counter=0; drop_count=0; end flag=0; go CLEAR (total=0 -> DRAW).
//  CLEAR: in_ready=0; write CLEAR_COLOR to back_base+k, k=0..total-1; k advances only on an
//   accepted write; last accepted write -> DRAW.
//  DRAW: in_ready = !fb_wr_en | fb_wr_ready (single output register, no skid buffer).
//   Accepted pixel with in_draw=1, x<W, y<H, idx=y*W+x < BUF_WORDS: next cycle fb_wr_en=1,
//   fb_wr_addr=back_base+idx, fb_wr_data=in_color (latency 1). in_draw=0: consumed, no write.
//   in_draw=1 but out of range: consumed, no write, drop_count++ (saturates at 16'hFFFF).
//  fb_wr_en/addr/data held stable while fb_wr_en & !fb_wr_ready.
//  back_base = (!front_buf)*BUF_WORDS.
//  End flag set on frame_end rising edge (0->1 between consecutive cycles) in CLEAR or DRAW.
//   In DRAW with end flag set: go DRAIN; a pixel accepted in that same cycle still writes.
//  DRAIN: in_ready=0; when no write is pending (fb_wr_en=0, or final write accepted this
//   cycle) -> SWAP.
//  SWAP: one cycle; front_buf toggles, swap_done=1 for that cycle; -> IDLE.
//  frame_start outside IDLE is ignored. frame_end held high across frames causes no new edge.
//  Reset mid-frame aborts the pending write; front_buf returns to 0.
// TESTING
//  W=4,H=2, frame_start, fb_wr_ready=1 -> 8 clear writes, addr 0x100000..0x100007 value 0x00.
//  DRAW x=3,y=1,color=0x5A,draw=1 -> next cycle fb_wr_en=1, addr 0x100007, data 0x5A.
//  Pixels x=4,y=0 and x=0,y=2 with draw=1 -> no writes, drop_count=2; draw=0 pixel -> 0 writes.
//  fb_wr_ready=0 for 3 cycles while write pending -> in_ready=0, addr/data stable, then 1 write.
//  frame_end 0->1 during CLEAR -> clear completes, DRAW 1 cycle, DRAIN, SWAP: front_buf=1,
//   swap_done pulses; next frame clears addresses 0x000000.. (back_base=0).
//  reset_n=0 mid-DRAW with fb_wr_en=1 -> fb_wr_en, in_ready, busy 0 immediately; front_buf=0.

Source files
------------

// File: rtl/framebuffer_writer_if.sv
// Pixel stream from the rasterizer plus the framebuffer RAM write port.
// The slave modport is the framebuffer writer: it consumes pixels and
// issues RAM writes; the master modport is the surrounding environment.
interface framebuffer_writer_if #(
  parameter int COLOR_W   = 8,
  parameter int FB_ADDR_W = 21
);
  logic [COLOR_W-1:0]   in_color;
  logic [10:0]          in_x;
  logic [10:0]          in_y;
  logic [10:0]          in_width;
  logic [10:0]          in_height;
  logic                 in_draw;
  logic                 in_valid;
  logic                 in_ready;
  logic                 fb_wr_en;
  logic [FB_ADDR_W-1:0] fb_wr_addr;
  logic [COLOR_W-1:0]   fb_wr_data;
  logic                 fb_wr_ready;

  modport master (
    output in_color, in_x, in_y, in_width, in_height, in_draw, in_valid, fb_wr_ready,
    input  in_ready, fb_wr_en, fb_wr_addr, fb_wr_data
  );

  modport slave (
    input  in_color, in_x, in_y, in_width, in_height, in_draw, in_valid, fb_wr_ready,
    output in_ready, fb_wr_en, fb_wr_addr, fb_wr_data
  );
endinterface

// File: rtl/framebuffer_writer.sv
// Framebuffer writer: clears the back buffer at frame start, writes covered
// in-range pixels into it, then swaps front/back once the frame has ended
// and the last write has drained. A single output register holds the RAM
// write; it is shared by the clear sweep and the pixel path.
module framebuffer_writer #(
  parameter int                 COLOR_W     = 8,
  parameter int                 BUF_WORDS   = 1048576,
  parameter int                 FB_ADDR_W   = 21,
  parameter logic [COLOR_W-1:0] CLEAR_COLOR = '0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 frame_start,
  input  logic                 frame_end,
  framebuffer_writer_if.slave  bus,
  output logic                 front_buf,
  output logic                 busy,
  output logic                 swap_done,
  output logic [15:0]          drop_count
);

  typedef enum logic [2:0] {IDLE, CLEAR, DRAW, DRAIN, SWAP} state_t;

  state_t               state, state_nxt;
  logic [10:0]          w_q, h_q;
  logic [FB_ADDR_W-1:0] total_q, total_nxt, clr_cnt, back_base, wr_addr;
  logic [COLOR_W-1:0]   wr_data;
  logic                 wr_en, end_flag, fe_q;
  logic [21:0]          prod;
  logic [22:0]          idx;
  logic                 wr_acc, pix_acc, in_range, pix_wr, pix_drop, clr_last, fe_rise;

  assign prod      = 22'(bus.in_width) * 22'(bus.in_height);
  assign total_nxt = (prod > 22'(BUF_WORDS)) ? FB_ADDR_W'(BUF_WORDS) : FB_ADDR_W'(prod);
  assign back_base = front_buf ? '0 : FB_ADDR_W'(BUF_WORDS);
  assign idx       = 23'(bus.in_y) * 23'(w_q) + 23'(bus.in_x);
  assign in_range  = (bus.in_x < w_q) && (bus.in_y < h_q) && (idx < 23'(BUF_WORDS));

  assign wr_acc   = wr_en & bus.fb_wr_ready;
  assign pix_acc  = bus.in_valid & bus.in_ready;
  assign pix_wr   = pix_acc & bus.in_draw & in_range;
  assign pix_drop = pix_acc & bus.in_draw & ~in_range;
  assign clr_last = (clr_cnt == total_q - FB_ADDR_W'(1));
  assign fe_rise  = frame_end & ~fe_q;

  // Accepting a pixel needs the output register free, or freeing this cycle.
  assign bus.in_ready   = (state == DRAW) && (!wr_en || bus.fb_wr_ready);
  assign bus.fb_wr_en   = wr_en;
  assign bus.fb_wr_addr = wr_addr;
  assign bus.fb_wr_data = wr_data;
  assign busy           = (state != IDLE);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (frame_start) state_nxt = (total_nxt == '0) ? DRAW : CLEAR;
      CLEAR: if (wr_acc && clr_last) state_nxt = DRAW;
      DRAW:  if (end_flag) state_nxt = DRAIN;
      DRAIN: if (!wr_en || wr_acc) state_nxt = SWAP;
      SWAP:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Frame geometry, clear progress, end-of-frame edge tracking, drop counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      w_q        <= '0;
      h_q        <= '0;
      total_q    <= '0;
      clr_cnt    <= '0;
      end_flag   <= 1'b0;
      fe_q       <= 1'b0;
      drop_count <= '0;
    end else begin
      fe_q <= frame_end;
      if (state == IDLE && frame_start) begin
        w_q        <= bus.in_width;
        h_q        <= bus.in_height;
        total_q    <= total_nxt;
        clr_cnt    <= '0;
        end_flag   <= 1'b0;
        drop_count <= '0;
      end
      if ((state == CLEAR || state == DRAW) && fe_rise) end_flag <= 1'b1;
      if (state == CLEAR && wr_acc) clr_cnt <= clr_cnt + FB_ADDR_W'(1);
      if (pix_drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
    end
  end

  // Write output register: clear sweep first, then pixel writes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      if (wr_acc) wr_en <= 1'b0;
      if (state == IDLE && frame_start && total_nxt != '0) begin
        wr_en   <= 1'b1;
        wr_addr <= back_base;
        wr_data <= CLEAR_COLOR;
      end
      if (state == CLEAR && wr_acc && !clr_last) begin
        wr_en   <= 1'b1;
        wr_addr <= wr_addr + FB_ADDR_W'(1);
      end
      if (pix_wr) begin
        wr_en   <= 1'b1;
        wr_addr <= back_base + FB_ADDR_W'(idx);
        wr_data <= bus.in_color;
      end
    end
  end

  // Buffer swap: front_buf and swap_done change together on leaving SWAP
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      front_buf <= 1'b0;
      swap_done <= 1'b0;
    end else begin
      swap_done <= (state == SWAP);
      if (state == SWAP) front_buf <= ~front_buf;
    end
  end

endmodule

// File: tb/tb_framebuffer_writer.sv
// Bench for framebuffer_writer: randomized frames and pixels against a
// queue-based reference of the expected RAM write sequence.
module tb_framebuffer_writer;
  localparam int CW  = 8;
  localparam int BUF = 64;
  localparam int AW  = 7;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        frame_start = 1'b0;
  logic        frame_end = 1'b0;
  logic        front_buf, busy, swap_done;
  logic [15:0] drop_count;

  framebuffer_writer_if #(.COLOR_W(CW), .FB_ADDR_W(AW)) bus ();

  framebuffer_writer #(.COLOR_W(CW), .BUF_WORDS(BUF), .FB_ADDR_W(AW), .CLEAR_COLOR(8'h00)) dut (
    .clk(clk), .reset_n(reset_n), .frame_start(frame_start), .frame_end(frame_end),
    .bus(bus), .front_buf(front_buf), .busy(busy), .swap_done(swap_done),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  typedef struct { logic [AW-1:0] addr; logic [CW-1:0] data; } wr_t;
  wr_t exp_q[$];

  int vectors = 0, miscompares = 0;
  int rdy_mode = 2;          // 0 random, 1 never ready, 2 always ready
  int front_model = 0;
  int cur_w, cur_h, cur_base, exp_drop;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // RAM back-pressure
  initial forever begin
    @(posedge clk); #1;
    case (rdy_mode)
      0: bus.fb_wr_ready = ($urandom_range(0, 3) != 0);
      1: bus.fb_wr_ready = 1'b0;
      default: bus.fb_wr_ready = 1'b1;
    endcase
  end

  // Monitor: scoreboard pop on every accepted write, plus hold/ready rules
  initial begin
    bit stall;
    logic [AW-1:0] pa;
    logic [CW-1:0] pd;
    wr_t e;
    stall = 0; pa = '0; pd = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) stall = 0;
      else begin
        if (stall) begin
          chk("stall_en_hold", {31'd0, bus.fb_wr_en}, 32'd1);
          chk("stall_addr_hold", 32'(bus.fb_wr_addr), 32'(pa));
          chk("stall_data_hold", 32'(bus.fb_wr_data), 32'(pd));
        end
        if (bus.fb_wr_en && !bus.fb_wr_ready) chk("in_ready_while_stalled", {31'd0, bus.in_ready}, 32'd0);
        if (!busy) chk("in_ready_idle", {31'd0, bus.in_ready}, 32'd0);
        if (bus.fb_wr_en && bus.fb_wr_ready) begin
          if (exp_q.size() == 0) fail_now($sformatf("unexpected_write addr 0x%0h data 0x%0h required none",
                                                     bus.fb_wr_addr, bus.fb_wr_data));
          else begin
            e = exp_q.pop_front();
            chk("wr_addr", 32'(bus.fb_wr_addr), 32'(e.addr));
            chk("wr_data", 32'(bus.fb_wr_data), 32'(e.data));
          end
        end
        stall = bus.fb_wr_en && !bus.fb_wr_ready;
        pa = bus.fb_wr_addr;
        pd = bus.fb_wr_data;
      end
    end
  end

  // Reference: a frame clears min(W*H, BUF) words of the back buffer
  task automatic start_frame(input int w, input int h);
    int tot;
    @(posedge clk); #1;
    frame_start = 1'b1;
    bus.in_width = 11'(w);
    bus.in_height = 11'(h);
    cur_w = w; cur_h = h; exp_drop = 0;
    cur_base = (front_model != 0) ? 0 : BUF;
    tot = (w * h > BUF) ? BUF : w * h;
    for (int k = 0; k < tot; k++) exp_q.push_back('{AW'(cur_base + k), CW'(0)});
    @(posedge clk); #1;
    frame_start = 1'b0;
  endtask

  // Reference: an accepted covered pixel writes base + y*W + x if inside the
  // frame and the buffer, otherwise it counts as dropped
  task automatic send_pixel(input int x, input int y, input logic [CW-1:0] c, input bit d);
    bit acc;
    bus.in_x = 11'(x); bus.in_y = 11'(y); bus.in_color = c; bus.in_draw = d;
    bus.in_valid = 1'b1;
    acc = 0;
    for (int t = 0; t < 500 && !acc; t++) begin
      @(negedge clk);
      if (bus.in_ready) acc = 1;
    end
    if (!acc) fail_now("in_ready_timeout got 0 required 1");
    else if (d) begin
      if (x < cur_w && y < cur_h && (y * cur_w + x) < BUF)
        exp_q.push_back('{AW'(cur_base + y * cur_w + x), c});
      else exp_drop++;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic end_frame();
    bit got;
    logic old;
    old = (front_model != 0);
    frame_end = 1'b1;
    got = 0;
    for (int t = 0; t < 3000 && !got; t++) begin
      @(negedge clk);
      if (swap_done) got = 1;
    end
    if (!got) fail_now("swap_done_timeout got 0 required 1");
    else begin
      chk("front_buf_swap", {31'd0, front_buf}, {31'd0, ~old});
      chk("drop_count", 32'(drop_count), 32'(exp_drop));
      chk("writes_outstanding", 32'(exp_q.size()), 32'd0);
      chk("busy_after_swap", {31'd0, busy}, 32'd0);
    end
    front_model = front_model ^ 1;
    @(posedge clk); #1;
    frame_end = 1'b0;
  endtask

  task automatic random_frame(input int w, input int h, input int npix);
    int n;
    start_frame(w, h);
    for (int p = 0; p < npix; p++) begin
      send_pixel($urandom_range(0, w + 1), $urandom_range(0, h + 1), CW'($urandom),
                 $urandom_range(0, 3) != 0);
      n = $urandom_range(0, 2);
      if (n > 0) begin repeat (n) @(posedge clk); #1; end
    end
    end_frame();
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    bit got;
    bus.in_valid = 1'b0; bus.in_draw = 1'b0; bus.in_color = '0;
    bus.in_x = '0; bus.in_y = '0; bus.in_width = '0; bus.in_height = '0;
    bus.fb_wr_ready = 1'b1;

    #1 reset_n = 1'b0;
    #20;
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("rst_fb_wr_en", {31'd0, bus.fb_wr_en}, 32'd0);
    chk("rst_front_buf", {31'd0, front_buf}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_swap_done", {31'd0, swap_done}, 32'd0);
    chk("rst_drop_count", 32'(drop_count), 32'd0);
    @(negedge clk); reset_n = 1'b1;
    rdy_mode = 0;

    // Directed 4x2 frame: one write, two drops, one discarded pixel
    start_frame(4, 2);
    send_pixel(3, 1, 8'h5A, 1);
    send_pixel(4, 0, 8'h11, 1);
    send_pixel(0, 2, 8'h22, 1);
    send_pixel(1, 1, 8'h33, 0);
    end_frame();

    // frame_end rises while still clearing
    start_frame(3, 3);
    repeat (2) @(posedge clk); #1;
    end_frame();

    // W*H larger than a buffer: clear clipped, idx >= BUF dropped
    random_frame(10, 10, 25);
    start_frame(10, 10);
    send_pixel(5, 8, 8'hA5, 1);
    send_pixel(3, 6, 8'h3C, 1);
    end_frame();

    // Zero-area frame goes straight to DRAW
    random_frame(0, 5, 4);

    for (int f = 0; f < 6; f++)
      random_frame($urandom_range(1, 9), $urandom_range(1, 9), $urandom_range(5, 20));

    // Reset while a pixel write is stalled
    rdy_mode = 2;
    start_frame(2, 2);
    got = 0;
    for (int t = 0; t < 200 && !got; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0) got = 1;
    end
    if (!got) fail_now("clear_timeout got writes pending required 0");
    rdy_mode = 1;
    send_pixel(1, 1, 8'hC3, 1);
    chk("pending_before_reset", {31'd0, bus.fb_wr_en}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_fb_wr_en", {31'd0, bus.fb_wr_en}, 32'd0);
    chk("midrst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_front_buf", {31'd0, front_buf}, 32'd0);
    exp_q.delete();
    front_model = 0;
    @(negedge clk); reset_n = 1'b1;
    rdy_mode = 0;

    random_frame(4, 4, 10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
